spi_peripheral: RTL
===================

Name: spi_peripheral

Overview:
SPI responder for the SP3_Digital generic register interface. It is the chip-side end of the link driven by the FPGA SPI controller. It decodes the serial frame (WnR bit, big-endian address, MSB-first data) and commits writes into a parameterised register bank whose contents drive chip configuration. On reads it streams register contents back on poci with zero turnaround. Read-only addresses return live status inputs.

Parameters:
ADDR_W, 4, address bits per frame; the bank holds 2**ADDR_W registers
REG_W, 32, register width in bits
RO_MASK, 16'h0000, bit i = 1 makes address i read-only (reads return status_in slice i)

Ports:
spi_clk  in  1  single clock (same clock as the controller's spi_clk); all logic on posedge
reset  in  1  synchronous, active-high reset
cs_b  in  1  chip select, active low
pico  in  1  controller-to-peripheral serial data, sampled on posedge while cs_b==0
poci  out  1  peripheral-to-controller serial data, registered
status_in  in  (2**ADDR_W)*REG_W  read-only values; slice i at [i*REG_W +: REG_W]
reg_out  out  (2**ADDR_W)*REG_W  flattened register bank contents
wr_strobe  out  1  one-cycle pulse when a write commits
wr_addr  out  ADDR_W  address of the last committed write, valid while wr_strobe==1

Behaviour:
- Reset (synchronous, one cycle): state=IDLE, every register=0, poci=0, wr_strobe=0, wr_addr=0, all counters and shift registers cleared. Reset mid-frame aborts the frame with no commit.
- Frame: bit 0 = WnR, bits 1..ADDR_W = address MSB-first, remaining bits = data MSB-first.
- States: IDLE, ADDR, WRITE, READ.
- IDLE: on an edge with cs_b==0, latch wnr<=pico, addr_cnt<=0, go to ADDR. Stay in IDLE while cs_b==1.
- ADDR: each edge with cs_b==0 shifts pico into the address register LSB and increments addr_cnt.
  - On the edge that samples address bit ADDR_W, the full address is {addr_sr[ADDR_W-2:0], pico}.
  - If wnr==1: go to WRITE, clear the data shift register and bit count.
  - If wnr==0: go to READ; load rd_sr with the selected word (status_in if RO, else register). On the same edge, poci<=word[REG_W-1] and rd_cnt<=1.
  - This gives zero turnaround: the first data bit is valid for the controller's first receive-sample edge.
- WRITE: each edge with cs_b==0 and bit_cnt<REG_W does wr_sr<={wr_sr[REG_W-2:0],pico} and bit_cnt+1. Bits beyond REG_W are discarded (bit_cnt saturates at REG_W).
- READ: each edge with cs_b==0 does poci<=rd_sr[REG_W-1-rd_cnt], rd_cnt+1. Once rd_cnt==REG_W, poci<=0 for the remaining bits.
- cs_b sampled high while in ADDR, WRITE or READ: go to IDLE and drive poci<=0. The frame ends on that edge.
- Commit happens only on a cs_b-high edge from WRITE with bit_cnt>=1 and address not RO.
  - Register <= wr_sr zero-extended, so short writes land right-justified.
  - wr_strobe=1 and wr_addr=addr for exactly the next cycle.
- No commit in these cases:
  - cs_b high in ADDR (aborted frame).
  - WRITE with 0 data bits.
  - Write to an RO address (register unchanged, no strobe).
- Back-to-back frames: one cs_b-high sample between frames is sufficient. The edge after commit may begin a new frame.
- poci=0 whenever the block is not in READ.
- reg_out is a direct view of the bank. A commit is visible on reg_out the cycle after the cs_b-high edge.
- Counter widths: $clog2(ADDR_W+1) and $clog2(REG_W+1) bits. Reads select with the full ADDR_W address, so there is no wrap.

Decomposition:
- spi_peripheral_pkg: state enum (IDLE/ADDR/WRITE/READ, 2-bit) and default constants ADDR_W_DEF, REG_W_DEF.
- One sub-module, spi_reg_bank: register array plus commit port and read mux. The mux selects status_in for RO addresses and exposes reg_out.
- The frame decoder FSM lives in spi_peripheral.

Test Plan:
- Write addr 0x3, 32 data bits 0xDEADBEEF, then cs_b high -> reg 3 = 0xDEADBEEF; wr_strobe high for 1 cycle with wr_addr=3; other registers stay 0.
- Read addr 0x3 after that write, 32 bits -> poci carries 1,1,0,1,1,1,1,0,… (0xDEADBEEF MSB-first), first bit valid on the edge after the last address bit; poci=0 after cs_b high.
- Write addr 0x5 with 8 bits 0xA5 -> reg 5 = 0x000000A5. Then write addr 0x1 with 40 bits (0x12345678 followed by 0xFF) -> reg 1 = 0x12345678.
- Read addr 0x3 with 40 bits -> last 8 poci bits are 0. cs_b high after WnR + 2 address bits -> no strobe, no register change, and an immediately following write to addr 0x2 of 0x1 succeeds.
- RO_MASK=16'h0100, status_in slice 8 = 0xCAFE0001: read addr 8 returns 0xCAFE0001; write 0xFFFFFFFF to addr 8 -> no strobe, reg 8 unchanged.
- Assert reset mid-read of addr 3 -> next cycle poci=0, state IDLE, reg 3 = 0; a new frame after reset deassertion decodes correctly.

Source files
------------

// File: rtl/spi_peripheral_pkg.sv
// Shared types and defaults for the SPI register-interface peripheral.
package spi_peripheral_pkg;

  localparam int ADDR_W_DEF = 4;
  localparam int REG_W_DEF  = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADDR  = 2'd1,
    WRITE = 2'd2,
    READ  = 2'd3
  } state_t;

endpackage

// File: rtl/spi_peripheral_if.sv
// Serial link between the FPGA SPI controller and the chip-side peripheral.
interface spi_peripheral_if;

  logic cs_b;
  logic pico;
  logic poci;

  modport master (output cs_b, output pico, input poci);
  modport slave  (input cs_b, input pico, output poci);

endinterface

// File: rtl/spi_reg_bank.sv
// Configuration register bank with a single commit port and a read mux that
// substitutes live status for read-only addresses.
module spi_reg_bank #(
  parameter int                    ADDR_W  = 4,
  parameter int                    REG_W   = 32,
  parameter logic [2**ADDR_W-1:0]  RO_MASK = '0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          wr_en,
  input  logic [ADDR_W-1:0]             wr_addr,
  input  logic [REG_W-1:0]              wr_data,
  input  logic [ADDR_W-1:0]             rd_addr,
  output logic [REG_W-1:0]              rd_data,
  input  logic [(2**ADDR_W)*REG_W-1:0]  status_in,
  output logic [(2**ADDR_W)*REG_W-1:0]  reg_out
);

  localparam int NREG = 2**ADDR_W;

  logic [REG_W-1:0] regs [NREG];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[wr_addr] <= wr_data;
    end
  end

  assign rd_data = RO_MASK[rd_addr] ? status_in[rd_addr*REG_W +: REG_W] : regs[rd_addr];

  for (genvar g = 0; g < NREG; g++) begin : g_view
    assign reg_out[g*REG_W +: REG_W] = regs[g];
  end

endmodule

// File: rtl/spi_peripheral.sv
// SPI responder: decodes WnR/address/data frames, commits writes into the
// register bank and streams reads back on poci with zero turnaround.
module spi_peripheral
  import spi_peripheral_pkg::*;
#(
  parameter int                    ADDR_W  = ADDR_W_DEF,
  parameter int                    REG_W   = REG_W_DEF,
  parameter logic [2**ADDR_W-1:0]  RO_MASK = '0
) (
  input  logic                          spi_clk,
  input  logic                          reset,
  spi_peripheral_if.slave               bus,
  input  logic [(2**ADDR_W)*REG_W-1:0]  status_in,
  output logic [(2**ADDR_W)*REG_W-1:0]  reg_out,
  output logic                          wr_strobe,
  output logic [ADDR_W-1:0]             wr_addr
);

  localparam int AC_W = $clog2(ADDR_W + 1);
  localparam int BC_W = $clog2(REG_W + 1);
  localparam logic [AC_W-1:0] ADDR_LAST = AC_W'(ADDR_W - 1);
  localparam logic [BC_W-1:0] REG_W_CNT = BC_W'(REG_W);

  state_t            state, state_next;
  logic              wnr;
  logic [AC_W-1:0]   addr_cnt;
  logic [ADDR_W-1:0] addr_sr, addr_full;
  logic [BC_W-1:0]   bit_cnt, rd_cnt;
  logic [REG_W-1:0]  wr_sr, rd_sr, rd_word;
  logic              addr_done, commit;

  // The last address bit is still on pico, so the read mux sees it directly.
  assign addr_full = {addr_sr[ADDR_W-2:0], bus.pico};
  assign addr_done = (addr_cnt == ADDR_LAST);

  always_ff @(posedge spi_clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    commit     = 1'b0;
    case (state)
      IDLE:  if (!bus.cs_b) state_next = ADDR;
      ADDR: begin
        if (bus.cs_b)       state_next = IDLE;
        else if (addr_done) state_next = wnr ? WRITE : READ;
      end
      WRITE: begin
        if (bus.cs_b) begin
          state_next = IDLE;
          commit     = (bit_cnt != '0) && !RO_MASK[addr_sr];
        end
      end
      READ:  if (bus.cs_b) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // rd_sr is preloaded already shifted by one because the MSB leaves on the
  // address edge itself.
  always_ff @(posedge spi_clk) begin
    if (reset) begin
      wnr       <= 1'b0;
      addr_cnt  <= '0;
      addr_sr   <= '0;
      bit_cnt   <= '0;
      rd_cnt    <= '0;
      wr_sr     <= '0;
      rd_sr     <= '0;
      bus.poci  <= 1'b0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
    end else begin
      wr_strobe <= commit;
      if (commit) wr_addr <= addr_sr;
      case (state)
        IDLE: begin
          bus.poci <= 1'b0;
          if (!bus.cs_b) begin
            wnr      <= bus.pico;
            addr_cnt <= '0;
          end
        end
        ADDR: begin
          bus.poci <= 1'b0;
          if (!bus.cs_b) begin
            addr_sr  <= addr_full;
            addr_cnt <= addr_cnt + 1'b1;
            if (addr_done) begin
              if (wnr) begin
                wr_sr   <= '0;
                bit_cnt <= '0;
              end else begin
                rd_sr    <= {rd_word[REG_W-2:0], 1'b0};
                bus.poci <= rd_word[REG_W-1];
                rd_cnt   <= BC_W'(1);
              end
            end
          end
        end
        WRITE: begin
          bus.poci <= 1'b0;
          if (!bus.cs_b && bit_cnt < REG_W_CNT) begin
            wr_sr   <= {wr_sr[REG_W-2:0], bus.pico};
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        READ: begin
          if (bus.cs_b) begin
            bus.poci <= 1'b0;
          end else if (rd_cnt < REG_W_CNT) begin
            bus.poci <= rd_sr[REG_W-1];
            rd_sr    <= {rd_sr[REG_W-2:0], 1'b0};
            rd_cnt   <= rd_cnt + 1'b1;
          end else begin
            bus.poci <= 1'b0;
          end
        end
        default: bus.poci <= 1'b0;
      endcase
    end
  end

  spi_reg_bank #(
    .ADDR_W  (ADDR_W),
    .REG_W   (REG_W),
    .RO_MASK (RO_MASK)
  ) u_bank (
    .clk       (spi_clk),
    .reset     (reset),
    .wr_en     (commit),
    .wr_addr   (addr_sr),
    .wr_data   (wr_sr),
    .rd_addr   (addr_full),
    .rd_data   (rd_word),
    .status_in (status_in),
    .reg_out   (reg_out)
  );

endmodule
